// File: rtl/photon_gate_sequencer_if.sv
// photon_gate_sequencer_if: valid/ready result channel towards the SPI readout
// res_data  : {frame_idx[15:0], count[15:0]}
// res_valid : result available (driven by master)
// res_ready : consumer accepts the result (driven by slave)
interface photon_gate_sequencer_if;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  modport master (output res_data, output res_valid, input res_ready);
  modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/photon_gate_sequencer.sv
// photon_gate_sequencer: per-trigger settle/clear/gate/drain/latch sequencing of a 16-bit photon counter
// clk50Mhz, rst (async, active-low) : clock and reset
// arm, trig, win_len, n_frames      : control inputs
// cnt_in / cnt_clr, cnt_gate        : counter interface
// res (master)                      : result handshake towards SPI readout
// busy, done, missed                : status
module photon_gate_sequencer #(
  parameter int SETTLE_CYC = 50,
  parameter int DRAIN_CYC  = 2,
  parameter int WIN_W      = 24
) (
  input  logic             clk50Mhz,
  input  logic             rst,
  input  logic             arm,
  input  logic             trig,
  input  logic [WIN_W-1:0] win_len,
  input  logic [15:0]      n_frames,
  input  logic [15:0]      cnt_in,
  output logic             cnt_clr,
  output logic             cnt_gate,
  output logic             busy,
  output logic             done,
  output logic [7:0]       missed,
  photon_gate_sequencer_if.master res
);
  typedef enum logic [2:0] {IDLE, SETTLE, CLEAR, COUNT, DRAIN, OUT} state_t;
  state_t           r_state, w_next;
  logic [WIN_W-1:0] r_cnt, r_win;
  logic [15:0]      r_fidx, r_nfr;
  logic             w_abort, w_load, w_last, w_clr, w_gate;
  assign w_abort = r_state != IDLE && !arm;
  assign w_load  = r_state == OUT && arm && (!res.res_valid || res.res_ready);
  assign w_last  = r_nfr != 16'd0 && r_fidx == r_nfr - 16'd1;
  assign busy    = r_state != IDLE;
  always_ff @(posedge clk50Mhz or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  // The OUT cycle is itself the last gate-low cycle before the sample,
  // so DRAIN only covers the remaining DRAIN_CYC-1 cycles.
  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = IDLE;
    else
      case (r_state)
        IDLE:    if (trig && arm) w_next = SETTLE;
        SETTLE:  if (r_cnt == WIN_W'(SETTLE_CYC - 1)) w_next = CLEAR;
        CLEAR:   w_next = COUNT;
        COUNT:   if (r_cnt == r_win - 1'b1) w_next = DRAIN_CYC > 1 ? DRAIN : OUT;
        DRAIN:   if (r_cnt == WIN_W'(DRAIN_CYC - 2)) w_next = OUT;
        OUT:     if (w_load) w_next = IDLE;
        default: w_next = IDLE;
      endcase
  end
  // Strobes are registered from the next state so they align with the state and never glitch.
  always_comb begin
    w_clr  = w_next == CLEAR;
    w_gate = w_next == COUNT;
  end
  always_ff @(posedge clk50Mhz or negedge rst)
    if (!rst) begin
      cnt_clr       <= 1'b0;
      cnt_gate      <= 1'b0;
      done          <= 1'b0;
      missed        <= 8'd0;
      r_cnt         <= '0;
      r_win         <= '0;
      r_nfr         <= 16'd0;
      r_fidx        <= 16'd0;
      res.res_data  <= 32'd0;
      res.res_valid <= 1'b0;
    end else begin
      cnt_clr  <= w_clr;
      cnt_gate <= w_gate;
      done     <= w_load && w_last;
      r_cnt    <= w_next != r_state ? '0 : r_cnt + 1'b1;
      if (r_state == IDLE && trig && arm) r_win <= win_len == '0 ? WIN_W'(1) : win_len;
      // Frame count is captured while idle and disarmed, i.e. up to the moment arming starts a sequence.
      if (r_state == IDLE && !arm) r_nfr <= n_frames;
      if (trig && r_state != IDLE && missed != 8'hFF) missed <= missed + 8'd1;
      if (w_abort) r_fidx <= 16'd0;
      else if (w_load) r_fidx <= w_last ? 16'd0 : r_fidx + 16'd1;
      if (w_load) begin
        res.res_data  <= {r_fidx, cnt_in};
        res.res_valid <= 1'b1;
      end else if (res.res_ready) res.res_valid <= 1'b0;
    end
endmodule
